uart_tx_ctrl: RTL and testbench

Transmit-side controller for the SoC's serial console. It buffers bytes written by the CPU-side peripheral bus in a small FIFO and sequences each one onto the serial output pin as an 8N1 frame at a fixed bit period. The block sits between the memory-mapped UART register and the top-level serial output of `accellant_soc`. It owns all serial timing, so software only writes bytes and polls `wr_ready`/`busy`.

---
 rtl/uart_tx_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_uart_tx_ctrl.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_ctrl.sv
`timescale 1ns/1ps
// uart_tx_ctrl
//   Transmit-side console UART controller. Bytes written by the peripheral
//   bus are queued in a small circular FIFO and serialised onto txd as 8N1
//   frames (start, 8 data bits LSB first, stop) at CLKS_PER_BIT cycles/bit.
//
// Ports
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   wr_valid    byte write request
//   wr_data     byte to transmit
//   wr_ready    FIFO has room (count < FIFO_DEPTH)
//   txd         registered serial output, idle high
//   busy        FSM not idle or FIFO non-empty
//   fifo_count  bytes queued, excluding the byte in flight
//
// State table
//   state   | meaning
//   S_IDLE  | line idle high, waiting for a queued byte
//   S_START | driving start bit (0)
//   S_DATA  | driving data bits LSB first, idx_q selects bit
//   S_STOP  | driving stop bit (1); may chain straight into S_START
module uart_tx_ctrl #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          wr_valid,
    input  logic [7:0]                    wr_data,
    output logic                          wr_ready,
    output logic                          txd,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t          state_q;
    logic [TW-1:0]   timer_q;
    logic [2:0]      idx_q;
    logic [7:0]      shift_q;
    logic            txd_q;

    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wptr_q, wptr_d;
    logic [AW-1:0]   rptr_q, rptr_d;
    logic [CW-1:0]   count_q, count_d;

    logic            timer_done;
    logic            push;
    logic            pop;

    assign timer_done = (timer_q == TW'(CLKS_PER_BIT - 1));

    // Full is judged on the registered count, so a push is refused while
    // full even if a pop happens on the same edge.
    assign wr_ready = (count_q < CW'(FIFO_DEPTH));
    assign push     = wr_valid && wr_ready;

    // Pop from IDLE immediately, or at the end of a stop bit so the next
    // frame starts with no idle cycle in between.
    assign pop = (count_q != '0) &&
                 ((state_q == S_IDLE) || ((state_q == S_STOP) && timer_done));

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push) begin
            wptr_d = wptr_q + AW'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: count_q gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            txd_q   <= 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    timer_q <= '0;
                    txd_q   <= 1'b1;
                    if (pop) begin
                        shift_q <= mem_q[rptr_q];
                        state_q <= S_START;
                        txd_q   <= 1'b0;
                    end
                end
                S_START: begin
                    if (timer_done) begin
                        timer_q <= '0;
                        idx_q   <= '0;
                        state_q <= S_DATA;
                        txd_q   <= shift_q[0];
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                S_DATA: begin
                    if (timer_done) begin
                        timer_q <= '0;
                        if (idx_q == 3'd7) begin
                            state_q <= S_STOP;
                            txd_q   <= 1'b1;
                        end else begin
                            idx_q   <= idx_q + 3'd1;
                            shift_q <= shift_q >> 1;
                            // Next bit is shift_q[1] before the shift lands.
                            txd_q   <= shift_q[1];
                        end
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                S_STOP: begin
                    if (timer_done) begin
                        timer_q <= '0;
                        if (pop) begin
                            shift_q <= mem_q[rptr_q];
                            state_q <= S_START;
                            txd_q   <= 1'b0;
                        end else begin
                            state_q <= S_IDLE;
                            txd_q   <= 1'b1;
                        end
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    txd_q   <= 1'b1;
                end
            endcase
        end
    end

    assign txd        = txd_q;
    assign busy       = (state_q != S_IDLE) || (count_q != '0);
    assign fifo_count = count_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
`timescale 1ns/1ps
module tb_uart_tx_ctrl;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic       clk;
    logic       rst_n;
    logic       wr_valid;
    logic [7:0] wr_data;
    logic       wr_ready;
    logic       txd;
    logic       busy;
    logic [2:0] fifo_count;

    logic       wr_valid_d;
    logic [7:0] wr_data_d;
    logic       wr_ready_def;
    logic       txd_def;
    logic       busy_def;
    logic [3:0] fifo_count_def;

    int total = 0;
    int bad   = 0;

    uart_tx_ctrl #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_data(wr_data),
        .wr_ready(wr_ready), .txd(txd), .busy(busy), .fifo_count(fifo_count)
    );

    uart_tx_ctrl dut_def (
        .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid_d), .wr_data(wr_data_d),
        .wr_ready(wr_ready_def), .txd(txd_def), .busy(busy_def),
        .fifo_count(fifo_count_def)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Waits for a start bit on txd (sampled at negedges) and captures a full
    // frame, requiring every bit to be stable for all CPB cycles.
    // waited = negedges seen high before the start bit, -1 on timeout.
    task automatic recv_frame(input int timeout, output logic [7:0] b,
                              output int waited, output bit ok);
        logic [9:0] v;
        waited = 0;
        ok     = 1'b1;
        b      = 8'h00;
        v      = '1;
        forever begin
            @(negedge clk);
            if (txd === 1'b0) break;
            waited++;
            if (waited > timeout) begin
                waited = -1;
                ok     = 1'b0;
                return;
            end
        end
        for (int i = 0; i < 10 * CPB; i++) begin
            if (i > 0) @(negedge clk);
            if (i % CPB == 0) v[i / CPB] = txd;
            else if (txd !== v[i / CPB]) ok = 1'b0;
        end
        if (v[0] !== 1'b0 || v[9] !== 1'b1) ok = 1'b0;
        b = v[8:1];
    endtask

    task automatic test_reset();
        rst_n = 1'b1; wr_valid = 1'b0; wr_data = 8'h00;
        wr_valid_d = 1'b0; wr_data_d = 8'h00;
        #2 rst_n = 1'b0;
        #1;
        total++; if (txd !== 1'b1) begin bad++; $display("FAIL reset_txd: got %b want 1", txd); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
        total++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", wr_ready); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single();
        logic [7:0] b; int w; bit ok;
        @(negedge clk);
        wr_valid = 1'b1; wr_data = 8'hA5;
        @(negedge clk);
        wr_valid = 1'b0;
        total++; if (fifo_count !== 3'd1) begin bad++; $display("FAIL single_count1: got %0d want 1", fifo_count); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy_rise: got %b want 1", busy); end
        total++; if (txd !== 1'b1) begin bad++; $display("FAIL single_txd_pre: got %b want 1", txd); end
        recv_frame(10, b, w, ok);
        total++; if (w != 0) begin bad++; $display("FAIL single_latency: got %0d want 0", w); end
        total++; if (!ok) begin bad++; $display("FAIL single_frame_shape: got bad want good"); end
        total++; if (b !== 8'hA5) begin bad++; $display("FAIL single_byte: got %h want a5", b); end
        total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL single_count0: got %0d want 0", fifo_count); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy_39: got %b want 1", busy); end
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy_40: got %b want 0", busy); end
        total++; if (txd !== 1'b1) begin bad++; $display("FAIL single_idle_txd: got %b want 1", txd); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_b [3];
        exp_b[0] = 8'h00; exp_b[1] = 8'hFF; exp_b[2] = 8'h55;
        fork
            begin
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    wr_valid = 1'b1; wr_data = exp_b[i];
                end
                @(negedge clk);
                wr_valid = 1'b0;
            end
            begin
                logic [7:0] b; int w; bit ok;
                for (int f = 0; f < 3; f++) begin
                    recv_frame(20, b, w, ok);
                    total++; if (!ok || b !== exp_b[f]) begin bad++; $display("FAIL b2b_byte%0d: got %h want %h", f, b, exp_b[f]); end
                    if (f > 0) begin
                        total++; if (w != 0) begin bad++; $display("FAIL b2b_gap%0d: got %0d want 0", f, w); end
                    end
                end
            end
        join
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_busy_end: got %b want 0", busy); end
    endtask

    task automatic test_full();
        int accepted = 0;
        int peak = 0;
        logic ready_end = 1'b1;
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    @(negedge clk);
                    if (int'(fifo_count) > peak) peak = int'(fifo_count);
                    if (wr_ready) accepted++;
                    wr_valid = 1'b1; wr_data = 8'(8'h30 + i);
                end
                @(negedge clk);
                wr_valid = 1'b0;
                if (int'(fifo_count) > peak) peak = int'(fifo_count);
                ready_end = wr_ready;
                total++; if (accepted != 5) begin bad++; $display("FAIL full_accepted: got %0d want 5", accepted); end
                total++; if (peak != 4) begin bad++; $display("FAIL full_peak: got %0d want 4", peak); end
                total++; if (ready_end !== 1'b0) begin bad++; $display("FAIL full_ready: got %b want 0", ready_end); end
            end
            begin
                logic [7:0] b; int w; bit ok;
                for (int f = 0; f < 5; f++) begin
                    recv_frame(40, b, w, ok);
                    total++; if (!ok || b !== 8'(8'h30 + f)) begin bad++; $display("FAIL full_byte%0d: got %h want %h", f, b, 8'(8'h30 + f)); end
                end
                recv_frame(30, b, w, ok);
                total++; if (w != -1) begin bad++; $display("FAIL full_extra_frame: got wait %0d want none", w); end
            end
        join
    endtask

    task automatic test_wrap();
        fork
            begin
                int n = 0;
                int guard = 0;
                while (n < 12 && guard < 2000) begin
                    @(negedge clk);
                    guard++;
                    if (wr_ready) begin
                        wr_valid = 1'b1; wr_data = 8'(8'h10 + n); n++;
                    end else begin
                        wr_valid = 1'b0;
                    end
                end
                @(negedge clk);
                wr_valid = 1'b0;
            end
            begin
                logic [7:0] b; int w; bit ok;
                for (int f = 0; f < 12; f++) begin
                    recv_frame(200, b, w, ok);
                    total++; if (!ok || b !== 8'(8'h10 + f)) begin bad++; $display("FAIL wrap_byte%0d: got %h want %h", f, b, 8'(8'h10 + f)); end
                end
            end
        join
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL wrap_busy_end: got %b want 0", busy); end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] b; int w; bit ok;
        fork
            begin
                @(negedge clk); wr_valid = 1'b1; wr_data = 8'h11;
                @(negedge clk); wr_data = 8'h22;
                @(negedge clk); wr_data = 8'h33;
                @(negedge clk); wr_valid = 1'b0;
            end
            begin
                logic [7:0] b1; int w1; bit ok1;
                recv_frame(20, b1, w1, ok1);
                total++; if (!ok1 || b1 !== 8'h11) begin bad++; $display("FAIL rst_first_byte: got %h want 11", b1); end
                repeat (18) @(negedge clk);
                total++; if (txd !== 1'b0) begin bad++; $display("FAIL rst_pre_bit3: got %b want 0", txd); end
                total++; if (fifo_count !== 3'd1) begin bad++; $display("FAIL rst_pre_count: got %0d want 1", fifo_count); end
                #1 rst_n = 1'b0;
                #1;
                total++; if (txd !== 1'b1) begin bad++; $display("FAIL rst_async_txd: got %b want 1", txd); end
                total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL rst_async_count: got %0d want 0", fifo_count); end
                total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_async_busy: got %b want 0", busy); end
            end
        join
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        recv_frame(60, b, w, ok);
        total++; if (w != -1) begin bad++; $display("FAIL rst_silent_after: got wait %0d want none", w); end
        fork
            begin
                @(negedge clk); wr_valid = 1'b1; wr_data = 8'h5A;
                @(negedge clk); wr_valid = 1'b0;
            end
            begin
                logic [7:0] b2; int w2; bit ok2;
                recv_frame(20, b2, w2, ok2);
                total++; if (!ok2 || b2 !== 8'h5A) begin bad++; $display("FAIL rst_new_byte: got %h want 5a", b2); end
            end
        join
        @(negedge clk);
    endtask

    task automatic test_default_params();
        fork
            begin
                @(negedge clk); wr_valid_d = 1'b1; wr_data_d = 8'h41;
                @(negedge clk); wr_valid_d = 1'b0;
            end
            begin
                int waited = 0;
                int cnt = 0;
                int start_len = 0;
                int frame_len = 0;
                logic [7:0] v = 8'h00;
                forever begin
                    @(negedge clk);
                    if (txd_def === 1'b0) break;
                    waited++;
                    if (waited > 20) break;
                end
                total++; if (txd_def !== 1'b0) begin bad++; $display("FAIL def_start_seen: got %b want 0", txd_def); end
                if (txd_def === 1'b0) begin
                    while (cnt < 10000) begin
                        @(negedge clk);
                        cnt++;
                        if (start_len == 0 && txd_def === 1'b1) start_len = cnt;
                        if (cnt >= 868 && (cnt - 868) % 868 == 434 && (cnt - 868) / 868 < 8)
                            v[(cnt - 868) / 868] = txd_def;
                        if (busy_def === 1'b0) begin
                            frame_len = cnt;
                            break;
                        end
                    end
                end
                total++; if (start_len != 868) begin bad++; $display("FAIL def_start_len: got %0d want 868", start_len); end
                total++; if (frame_len != 8680) begin bad++; $display("FAIL def_frame_len: got %0d want 8680", frame_len); end
                total++; if (v !== 8'h41) begin bad++; $display("FAIL def_byte: got %h want 41", v); end
            end
        join
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_full();
        test_wrap();
        test_reset_midframe();
        test_default_params();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
